// File: rtl/bus_arbiter_16bit.sv
// Two-port round-robin arbiter with burst limiting, feeding one registered
// valid/ready output stage through a 16-bit 2:1 data mux.

module mux2x1_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sel,
    output logic [15:0] y
);
    assign y = sel ? b : a;
endmodule

module bus_arbiter_16bit #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt1,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             grant_id
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t      state;
    logic        last;
    logic [3:0]  beats;
    logic        can_accept;
    logic        xfer;
    logic        own_id;
    logic        own_req;
    logic        oth_req;
    logic [3:0]  beats_inc;
    logic        burst_end;
    logic [15:0] mux_y;

    assign can_accept = !out_valid || out_ready;
    assign gnt0       = (state == GRANT0) && req0 && can_accept;
    assign gnt1       = (state == GRANT1) && req1 && can_accept;
    assign xfer       = gnt0 || gnt1;

    // grant_id doubles as the mux select, so it must track state, not last
    assign grant_id = (state == GRANT1) ? 1'b1 :
                      (state == GRANT0) ? 1'b0 : last;

    mux2x1_16bit u_mux (
        .a   (data0),
        .b   (data1),
        .sel (grant_id),
        .y   (mux_y)
    );

    // Owner-relative view of the requests while in a grant state
    assign own_id    = (state == GRANT1);
    assign own_req   = own_id ? req1 : req0;
    assign oth_req   = own_id ? req0 : req1;
    assign beats_inc = beats + {3'b000, xfer};
    assign burst_end = !own_req || (xfer && (beats_inc == 4'(MAX_BURST)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            beats     <= 4'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (xfer) begin
                out_data  <= mux_y;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    beats <= 4'd0;
                    if (req0 && (!req1 || last)) begin
                        state <= GRANT0;
                        last  <= 1'b0;
                    end else if (req1) begin
                        state <= GRANT1;
                        last  <= 1'b1;
                    end
                end
                default: begin
                    if (burst_end) begin
                        beats <= 4'd0;
                        if (oth_req) begin
                            state <= own_id ? GRANT0 : GRANT1;
                            last  <= !own_id;
                        end else if (own_req) begin
                            // burst expiry with no competitor: re-grant, no bubble
                            state <= own_id ? GRANT1 : GRANT0;
                            last  <= own_id;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        beats <= beats_inc;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/bus_arbiter_16bit.md
# bus_arbiter_16bit

Round-robin arbiter that shares one 16-bit output channel between two requesters. It grants one requester at a time and steers that requester's data through an internal `mux2x1_16bit` instance (a = port 0, b = port 1). It registers the selected word into a valid/ready output stage. The block sits between two 16-bit producers (e.g. ALU result and memory read-back) and a single downstream consumer such as the register-file write port.

## Interface
- `WIDTH`, 16, data width; fixed at 16 to match `mux2x1_16bit`.
- `MAX_BURST`, 4, maximum beats accepted from one requester per grant; legal range 1–15.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`  in  1  port 0 has a word on `data0`.
- `data0`  in  16  port 0 data.
- `gnt0`  out  1  port 0 word consumed this cycle.
- `req1`  in  1  port 1 has a word on `data1`.
- `data1`  in  16  port 1 data.
- `gnt1`  out  1  port 1 word consumed this cycle.
- `out_data`  out  16  registered output word.
- `out_valid`  out  1  `out_data` holds an unconsumed word.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `grant_id`  out  1  owner of the current/last grant; also the mux `sel`.

## Operation
- FSM states: IDLE, GRANT0, GRANT1.
- Round-robin pointer `last` holds the most recently granted port. Reset value is 1, so port 0 wins the first tie.
- `can_accept` = !`out_valid` | `out_ready`.
- `gntX` = (state==GRANTX) & `reqX` & `can_accept`. It is combinational from state, `req` and `out_ready`, and is never high in IDLE.
- Requester handshake: a word transfers on any edge where `gntX`=1. The requester may change `dataX` or drop `reqX` after that edge. It holds `dataX` stable while `reqX`=1 and `gntX`=0.
- Output register:
  - On a transfer, `out_data` <= mux output and `out_valid` <= 1.
  - Otherwise, if `out_ready`, `out_valid` <= 0.
  - `out_data` holds its value when `out_valid`=0.
- Burst counter (4 bits):
  - Cleared on every state change.
  - Incremented on each transfer.
- IDLE transitions:
  - Only `req0` → GRANT0.
  - Only `req1` → GRANT1.
  - Both requesting → grant the port ≠ `last`.
  - Neither requesting → stay in IDLE.
- GRANTX release occurs when either:
  - `reqX`=0, or
  - a transfer makes the count reach `MAX_BURST`.
- On release:
  - If the other port requests → go to GRANT(other).
  - Else, if `reqX` is still 1 (burst expiry) → re-enter GRANTX with the counter cleared.
  - Else → IDLE.
- `last` updates to X on each entry into GRANTX.
- `grant_id` = 1 in GRANT1. It holds `last` in IDLE and GRANT0 (i.e. 0 in GRANT0).
- Reset (asynchronous, at any time, including mid-burst or with `out_valid`=1):
  - state=IDLE, `last`=1, counter=0.
  - `out_valid`=0, `out_data`=0, `grant_id`=1.
  - `gnt0`=`gnt1`=0 immediately.
  - A pending output word is discarded.

## Timing
- Request to grant: `req` seen in IDLE at edge N → state GRANTX after edge N → `gntX` high in cycle N+1 (if `can_accept`).
- Grant to output: transfer at edge M → `out_valid`/`out_data` valid after edge M. That gives 2 cycles from IDLE request to `out_valid`.
- Throughput: one word per cycle while `out_ready`=1.
- Backpressure: if `out_valid`=1 and `out_ready`=0, `gntX`=0, so no word is lost or overwritten.
- Grant switch: zero dead cycles. The other port's `gnt` can be high in the cycle right after the releasing edge.
- Simultaneous events:
  - `req` drop and burst expiry on the same edge → treated as one release.
  - Both requests rising together in IDLE → the round-robin rule decides.

## Test plan
- Reset, then `req0`=1 with `data0`=0x1234 and `out_ready`=1 → `gnt0` high in cycle 1; `out_data`=0x1234 with `out_valid`=1 after cycle 1; `grant_id`=0.
- Both requesters continuously requesting, `MAX_BURST`=4, `out_ready`=1 → output beats arrive in the order 0,0,0,0,1,1,1,1,0,… with no idle cycles.
- Hold `out_ready`=0 for 3 cycles during a port-1 burst of 0xA001, 0xA002 → `gnt1` low for those cycles, `out_data` holds 0xA001, and both words are delivered in order with no duplicates.
- `req0` drops after 2 beats while `req1`=1 → grant moves to port 1 on the next cycle, the counter restarts, and `grant_id`=1.
- Assert `reset` asynchronously mid-burst with `out_valid`=1 → `out_valid`, `gnt0` and `gnt1` go to 0 immediately. After release, with both requesting, port 0 is granted first.
- Only `req1`=1 for 10 cycles with `MAX_BURST`=4 → all 10 words are transferred back-to-back; the burst expiry re-grants port 1 without a bubble.
